// File: rtl/r3_weight_mask_pkg.sv
// rtl/r3_weight_mask_pkg.sv - shared constants, state codes and helpers for r3_weight_mask
package r3_weight_mask_pkg;

  localparam int P       = 761;
  localparam int W       = 286;
  localparam int NWORDS  = 24;
  localparam int Q_DEPTH = 5;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_CHECK = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [63:0] DEF_ONES = 64'h5555_5555_5555_5555;
  localparam logic [63:0] DEF_TAIL = 64'h0555_5555_5555_5555;

  // Word 23 carries only coefficients 736..760, i.e. the low 25 lanes.
  localparam logic [31:0] LAST_LANES = 32'h01FF_FFFF;

  function automatic logic [63:0] lanes_to_bits(input logic [31:0] lanes);
    logic [63:0] b;
    for (int i = 0; i < 32; i++) begin
      b[2*i]   = lanes[i];
      b[2*i+1] = lanes[i];
    end
    return b;
  endfunction

  function automatic logic [63:0] default_word(input logic [Q_DEPTH-1:0] addr);
    if (addr < 5'd8)
      return DEF_ONES;
    else if (addr == 5'd8)
      return DEF_TAIL;
    else
      return 64'd0;
  endfunction

endpackage

// File: rtl/r3_weight_mask_if.sv
// rtl/r3_weight_mask_if.sv - multiplier read port, result read port and status bundle
interface r3_weight_mask_if;
  import r3_weight_mask_pkg::*;

  logic               in_ready;
  logic [5:0]         rd_addr;
  logic [63:0]        rd_din;
  logic [Q_DEPTH-1:0] out_addr;
  logic [63:0]        out_dout;
  logic [9:0]         weight;
  logic               weight_ok;
  logic               valid;

  modport slave (
    input  in_ready, rd_din, out_addr,
    output rd_addr, out_dout, weight, weight_ok, valid
  );

  modport master (
    output in_ready, rd_din, out_addr,
    input  rd_addr, out_dout, weight, weight_ok, valid
  );

endinterface

// File: rtl/bram_p.sv
// rtl/bram_p.sv - simple dual-port RAM, one write port, registered read port
module bram_p #(
  parameter int Q_DEPTH = 5,
  parameter int WIDTH   = 64
) (
  input  logic               clk,
  input  logic               wen,
  input  logic [Q_DEPTH-1:0] waddr,
  input  logic [WIDTH-1:0]   wdata,
  input  logic [Q_DEPTH-1:0] raddr,
  output logic [WIDTH-1:0]   rdata
);

  logic [WIDTH-1:0] mem [2**Q_DEPTH];

  always_ff @(posedge clk) begin
    if (wen)
      mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/r3_popcount32.sv
// rtl/r3_popcount32.sv - counts nonzero 2-bit coefficients in the enabled lanes of a word
module r3_popcount32 (
  input  logic [63:0] word,
  input  logic [31:0] lanes,
  output logic [5:0]  count
);

  always_comb begin
    count = '0;
    for (int i = 0; i < 32; i++)
      count = count + 6'((word[2*i] | word[2*i+1]) & lanes[i]);
  end

endmodule

// File: rtl/r3_weight_mask.sv
// rtl/r3_weight_mask.sv - buffers the R3 product, checks its weight, serves r or the default vector
module r3_weight_mask
  import r3_weight_mask_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  r3_weight_mask_if.slave  bus
);

  logic [1:0]         state;
  logic [5:0]         ctr;
  logic [9:0]         acc;
  logic [9:0]         weight_q;
  logic               ok_q;
  logic [Q_DEPTH-1:0] addr_q;
  logic [31:0]        lanes;
  logic [63:0]        word_masked;
  logic [5:0]         pc;
  logic               wr_en;
  logic [Q_DEPTH-1:0] wr_addr;
  logic [63:0]        buf_rdata;

  // ctr == k+1 means word k is on rd_din; the last word has only 25 lanes.
  assign lanes       = (ctr == 6'(NWORDS)) ? LAST_LANES : '1;
  assign word_masked = bus.rd_din & lanes_to_bits(lanes);
  assign wr_en       = (state == S_READ) && (ctr != 6'd0);
  assign wr_addr     = Q_DEPTH'(ctr - 6'd1);

  r3_popcount32 u_popcount (
    .word  (bus.rd_din),
    .lanes (lanes),
    .count (pc)
  );

  bram_p #(
    .Q_DEPTH (Q_DEPTH),
    .WIDTH   (64)
  ) u_buf (
    .clk   (clk),
    .wen   (wr_en),
    .waddr (wr_addr),
    .wdata (word_masked),
    .raddr (bus.out_addr),
    .rdata (buf_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      ctr      <= '0;
      acc      <= '0;
      weight_q <= '0;
      ok_q     <= 1'b0;
      addr_q   <= '0;
    end else begin
      addr_q <= bus.out_addr;
      case (state)
        S_IDLE: begin
          if (bus.in_ready) begin
            acc   <= '0;
            ctr   <= '0;
            state <= S_READ;
          end
        end
        S_READ: begin
          if (ctr != 6'd0)
            acc <= acc + {4'd0, pc};
          if (ctr == 6'(NWORDS))
            state <= S_CHECK;
          else
            ctr <= ctr + 6'd1;
        end
        S_CHECK: begin
          weight_q <= acc;
          ok_q     <= (acc == 10'(W));
          state    <= S_DONE;
        end
        S_DONE: ;
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    bus.out_dout = 64'd0;
    if (addr_q < Q_DEPTH'(NWORDS))
      bus.out_dout = ok_q ? buf_rdata : default_word(addr_q);
  end

  assign bus.rd_addr   = ((state == S_READ) && (ctr < 6'(NWORDS))) ? ctr : 6'd0;
  assign bus.weight    = weight_q;
  assign bus.weight_ok = ok_q;
  assign bus.valid     = (state == S_DONE);

endmodule

// File: tb/tb_r3_weight_mask.sv
// tb/tb_r3_weight_mask.sv - directed bench for r3_weight_mask with a multiplier memory model
module tb_r3_weight_mask;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  r3_weight_mask_if bus ();

  r3_weight_mask dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [63:0] mem [24];
  logic [63:0] exp_q [$];
  int total = 0;
  int bad   = 0;

  // Multiplier DO port: synchronous read, data one cycle after the address.
  always @(posedge clk)
    bus.rd_din <= (int'(bus.rd_addr) < 24) ? mem[int'(bus.rd_addr)] : 64'd0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 24; i++) mem[i] = 64'd0;
  endtask

  task automatic set_coef(input int i, input logic [1:0] v);
    mem[i/32][2*(i%32) +: 2] = v;
  endtask

  // n nonzero coefficients cycling 01/10/11, every other position, from the bottom or the top.
  task automatic gen(input int n, input bit from_top);
    clear_mem();
    for (int i = 0; i < n; i++)
      set_coef(from_top ? 760 - 2*i : 2*i, 2'((i % 3) + 1));
  endtask

  function automatic logic [63:0] exp_word(input int a, input bit ok);
    if (a >= 24) return 64'd0;
    if (ok) return (a == 23) ? (mem[a] & 64'h0003_FFFF_FFFF_FFFF) : mem[a];
    if (a < 8) return 64'h5555_5555_5555_5555;
    if (a == 8) return 64'h0555_5555_5555_5555;
    return 64'd0;
  endfunction

  task automatic start();
    bus.in_ready = 1'b1;
    @(posedge clk); #1;
    bus.in_ready = 1'b0;
  endtask

  task automatic run(input string tag, input int extra_at, input bit do_rst);
    int lat;
    if (do_rst) begin
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
    end
    start();
    lat = 0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      if (bus.valid) begin
        lat = n;
        break;
      end
      bus.in_ready = (n == extra_at);
    end
    bus.in_ready = 1'b0;
    chk({tag, "_latency"}, 64'(lat), 64'd26);
  endtask

  task automatic readback(input string tag, input int a, input bit ok);
    bus.out_addr = 5'(a);
    exp_q.push_back(exp_word(a, ok));
    @(posedge clk); #1;
    chk($sformatf("%s_word%0d", tag, a), bus.out_dout, exp_q.pop_front());
  endtask

  initial begin
    bus.in_ready = 1'b0;
    bus.out_addr = '0;
    clear_mem();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_valid", 64'(bus.valid), 64'd0);
    chk("reset_weight", 64'(bus.weight), 64'd0);
    chk("reset_weight_ok", 64'(bus.weight_ok), 64'd0);
    chk("reset_rd_addr", 64'(bus.rd_addr), 64'd0);
    rst = 1'b0;

    clear_mem();
    run("zero", 0, 1'b1);
    chk("zero_weight", 64'(bus.weight), 64'd0);
    chk("zero_ok", 64'(bus.weight_ok), 64'd0);
    readback("zero", 0, 1'b0);
    readback("zero", 7, 1'b0);
    readback("zero", 8, 1'b0);
    readback("zero", 9, 1'b0);
    readback("zero", 23, 1'b0);
    readback("zero", 31, 1'b0);

    gen(286, 1'b0);
    run("w286", 0, 1'b1);
    chk("w286_weight", 64'(bus.weight), 64'd286);
    chk("w286_ok", 64'(bus.weight_ok), 64'd1);
    for (int a = 0; a < 24; a++) readback("w286", a, 1'b1);

    gen(287, 1'b0);
    run("w287", 0, 1'b1);
    chk("w287_weight", 64'(bus.weight), 64'd287);
    chk("w287_ok", 64'(bus.weight_ok), 64'd0);
    readback("w287", 0, 1'b0);
    readback("w287", 8, 1'b0);
    readback("w287", 12, 1'b0);

    gen(285, 1'b1);
    run("w285", 0, 1'b1);
    chk("w285_weight", 64'(bus.weight), 64'd285);
    chk("w285_ok", 64'(bus.weight_ok), 64'd0);
    readback("w285", 0, 1'b0);
    readback("w285", 8, 1'b0);
    readback("w285", 23, 1'b0);

    gen(286, 1'b1);
    mem[23] = mem[23] | 64'hFFFC_0000_0000_0000;
    run("junk", 0, 1'b1);
    chk("junk_weight", 64'(bus.weight), 64'd286);
    chk("junk_ok", 64'(bus.weight_ok), 64'd1);
    readback("junk", 22, 1'b1);
    readback("junk", 23, 1'b1);
    readback("junk", 24, 1'b1);

    for (int i = 0; i < 24; i++) mem[i] = '1;
    run("all11", 0, 1'b1);
    chk("all11_weight", 64'(bus.weight), 64'd761);
    chk("all11_ok", 64'(bus.weight_ok), 64'd0);
    readback("all11", 0, 1'b0);

    gen(286, 1'b0);
    run("extra", 5, 1'b1);
    chk("extra_weight", 64'(bus.weight), 64'd286);
    chk("extra_ok", 64'(bus.weight_ok), 64'd1);
    bus.in_ready = 1'b1;
    @(posedge clk); #1;
    bus.in_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("done_pulse_valid", 64'(bus.valid), 64'd1);
    chk("done_pulse_weight", 64'(bus.weight), 64'd286);
    readback("done_pulse", 5, 1'b1);

    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    start();
    repeat (10) @(posedge clk);
    #1;
    chk("abort_rd_addr_ctr10", 64'(bus.rd_addr), 64'd10);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_valid", 64'(bus.valid), 64'd0);
    chk("abort_weight", 64'(bus.weight), 64'd0);
    chk("abort_rd_addr", 64'(bus.rd_addr), 64'd0);
    gen(286, 1'b1);
    run("restart", 0, 1'b0);
    chk("restart_weight", 64'(bus.weight), 64'd286);
    chk("restart_ok", 64'(bus.weight_ok), 64'd1);
    readback("restart", 23, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/r3_weight_mask.md
Name: r3_weight_mask

Overview:
- Downstream stage of the R3 multiplier in sntrup761 decapsulation.
- After the multiplier asserts valid, this block reads the 761-coefficient product r (24 x 64-bit words, 2 bits per coefficient) through the multiplier's DO_addr/DO read port and buffers it.
- It counts nonzero coefficients and checks the count against w = 286.
- It exposes either r (weight ok) or the fixed default vector (first w coefficients = 1, rest 0) on its own read port for the re-encapsulation stage.

Parameters:
- P, 761: number of coefficients.
- W, 286: required Hamming weight.
- Q_DEPTH, 5: log2 of buffer depth (32 words, 24 used).
- NWORDS, 24: words per polynomial.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous, active-high reset.
- in_ready  input  1  start pulse; wired to the multiplier's valid.
- rd_addr  output  6  word address to the multiplier's DO_addr.
- rd_din  input  64  multiplier DO; valid 1 cycle after rd_addr.
- out_addr  input  5  read address for the result.
- out_dout  output  64  result word; 1-cycle read latency.
- weight  output  10  nonzero-coefficient count of r.
- weight_ok  output  1  high when weight == W.
- valid  output  1  result ready.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst.
- Reset values: state IDLE, valid=0, weight_ok=0, weight=0, rd_addr=0, ctr=0.
- Coefficient c_i sits at word i/32, bits [2*(i%32)+1 : 2*(i%32)].
- A coefficient is nonzero iff its bit pair != 2'b00; 2'b01, 2'b10 and 2'b11 each count as one.
- Word 23 holds coefficients 736..760 in bits [49:0]. Bits [63:50] are excluded from the count and written to the buffer as zero.
- FSM IDLE -> READ -> CHECK -> DONE.
- IDLE: on in_ready=1, clear accumulator, set ctr=0, go to READ. in_ready is ignored in every other state.
- READ: rd_addr = ctr while ctr<24.
  - At ctr=k+1 (k=0..23), word k is on rd_din. The block adds popcount(pairwise OR, 0..32) to the accumulator and writes the masked word k into the internal buffer.
  - After the ctr=24 cycle, go to CHECK.
- CHECK: register weight = acc and weight_ok = (acc == W), then go to DONE.
- DONE: valid=1. Hold until rst; a further in_ready is ignored.
- Latency: valid rises on the 26th clock edge after the edge that samples in_ready.
- The accumulator is 10 bits wide (max 761). It never saturates or wraps.
- out_dout, registered, 1-cycle latency from out_addr:
  - weight_ok=1: buffer[out_addr].
  - weight_ok=0: default word for the registered out_addr:
    - addr 0..7 -> 64'h5555_5555_5555_5555.
    - addr 8 -> 64'h0555_5555_5555_5555 (30 ones).
    - addr 9..31 -> 0.
- out_dout is defined only while valid=1. out_addr >= 24 returns 0 in both modes.
- Reset mid-operation (any state): return to IDLE with reset values. The buffer contents are don't-care. The next in_ready restarts cleanly.

Decomposition:
- Shared package: P, W, NWORDS, Q_DEPTH, the state encoding, and the default-word constants DEF_ONES (all-01) and DEF_TAIL (30 ones).
- Reuse the codebase's bram_p (Q_DEPTH=5) as the result buffer.
- One natural sub-module: r3_popcount32. It takes a 64-bit word and a 32-bit valid-lane mask and returns a 6-bit count of nonzero pairs. It is combinational and is instantiated once.

Test Plan:
- All-zero r, in_ready pulse -> valid 26 edges later; weight=0, weight_ok=0; out word0=64'h5555_5555_5555_5555, word8=64'h0555_5555_5555_5555, word9=0, word23=0.
- r with exactly 286 nonzero coefficients using mixed 01/10/11 -> weight=286, weight_ok=1; out_dout equals r word-for-word for addresses 0..23.
- r with 287 nonzero, then a separate run with 285 -> weight 287/285, weight_ok=0; default vector is output in both runs.
- r with 286 valid nonzero plus junk 64'hFFFC_0000_0000_0000 in word 23 -> weight=286, weight_ok=1; out word23 bits [63:50]=0.
- All 761 coefficients = 2'b11 -> weight=761 with no overflow, weight_ok=0.
- Extra in_ready pulses during READ and DONE -> no effect on weight or timing. rst asserted at ctr=10 of READ -> valid=0 next cycle; a fresh in_ready then gives a correct weight for the new input.
